// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue between fetch and decode
//
// Circular FIFO of {pc, inst} pairs with first-word fall-through dequeue.
// Ports:
//   clk_i, rst_n_i               clock, asynchronous active-low reset
//   flush_i                      redirect: discard all entries
//   enq_valid_i/enq_pc_i/enq_inst_i   instruction from fetch / imem
//   full_o, afull_o              backpressure (afull leaves room for in-flight fetch)
//   deq_valid_o/deq_pc_o/deq_inst_o/deq_ready_i   head entry to decode
//   count_o                      occupancy
//   overflow_o                   sticky: an enqueue was dropped while full
module fetch_queue #(
    parameter int          DEPTH        = 8,
    parameter int          AFULL_MARGIN = 2,
    parameter logic [31:0] PC_RESET     = 32'h1ECE_B000
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       enq_valid_i,
    input  logic [31:0]                enq_pc_i,
    input  logic [31:0]                enq_inst_i,
    output logic                       full_o,
    output logic                       afull_o,
    output logic                       deq_valid_o,
    output logic [31:0]                deq_pc_o,
    output logic [31:0]                deq_inst_o,
    input  logic                       deq_ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [31:0]   INST_NOP = 32'h0000_0013;
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] MARGIN_P = PW'(AFULL_MARGIN);

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [PW-1:0] count;
    logic [PW-1:0] free_cnt;
    logic          overflow_q;
    // Last head value shown on deq_*; drives the outputs while empty.
    logic [31:0]   hold_pc_q;
    logic [31:0]   hold_inst_q;

    logic          empty;
    logic          full;
    logic          deq_fire;
    logic          enq_accept;
    logic          enq_drop;
    logic [63:0]   head_entry;

    assign empty    = (head_q == tail_q);
    assign full     = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    assign count    = tail_q - head_q;
    assign free_cnt = DEPTH_P - count;

    assign deq_fire   = ~empty & deq_ready_i & ~flush_i;
    // A full queue can still take a new entry when the head leaves this cycle.
    assign enq_accept = enq_valid_i & ~flush_i & (~full | deq_fire);
    assign enq_drop   = enq_valid_i & ~flush_i & full & ~deq_fire;

    assign head_entry = mem[head_q[AW-1:0]];

    assign full_o      = full;
    assign afull_o     = (free_cnt <= MARGIN_P);
    assign deq_valid_o = ~empty;
    assign deq_pc_o    = empty ? hold_pc_q   : head_entry[63:32];
    assign deq_inst_o  = empty ? hold_inst_q : head_entry[31:0];
    assign count_o     = count;
    assign overflow_o  = overflow_q;

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (enq_accept) begin
            mem[tail_q[AW-1:0]] <= {enq_pc_i, enq_inst_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            overflow_q  <= 1'b0;
            hold_pc_q   <= PC_RESET;
            hold_inst_q <= INST_NOP;
        end else begin
            if (enq_drop) begin
                overflow_q <= 1'b1;
            end
            if (flush_i) begin
                head_q      <= '0;
                tail_q      <= '0;
                hold_pc_q   <= PC_RESET;
                hold_inst_q <= INST_NOP;
            end else begin
                if (!empty) begin
                    hold_pc_q   <= head_entry[63:32];
                    hold_inst_q <= head_entry[31:0];
                end
                if (deq_fire) begin
                    head_q <= head_q + 1'b1;
                end
                if (enq_accept) begin
                    tail_q <= tail_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard testbench for fetch_queue
module tb_fetch_queue;

    localparam int          DEPTH    = 8;
    localparam int          MARGIN   = 2;
    localparam logic [31:0] PC_RST   = 32'h1ECE_B000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        enq_valid_i;
    logic [31:0] enq_pc_i;
    logic [31:0] enq_inst_i;
    logic        full_o;
    logic        afull_o;
    logic        deq_valid_o;
    logic [31:0] deq_pc_o;
    logic [31:0] deq_inst_o;
    logic        deq_ready_i;
    logic [3:0]  count_o;
    logic        overflow_o;

    fetch_queue #(.DEPTH(DEPTH), .AFULL_MARGIN(MARGIN), .PC_RESET(PC_RST)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .flush_i     (flush_i),
        .enq_valid_i (enq_valid_i),
        .enq_pc_i    (enq_pc_i),
        .enq_inst_i  (enq_inst_i),
        .full_o      (full_o),
        .afull_o     (afull_o),
        .deq_valid_o (deq_valid_o),
        .deq_pc_o    (deq_pc_o),
        .deq_inst_o  (deq_inst_o),
        .deq_ready_i (deq_ready_i),
        .count_o     (count_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] sb[$];
    logic [31:0] m_hold_pc;
    logic [31:0] m_hold_inst;
    logic        m_ovf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_hold_pc   = PC_RST;
        m_hold_inst = NOP;
        m_ovf       = 1'b0;
    endtask

    // Drive one cycle of inputs (called at posedge+1), check outputs mid-cycle,
    // then advance the model across the coming edge.
    task automatic cycle(input logic enq, input logic [31:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic fl);
        logic fire;
        logic accept;
        int   sz;
        enq_valid_i = enq;
        enq_pc_i    = pc;
        enq_inst_i  = inst;
        deq_ready_i = rdy;
        flush_i     = fl;
        #2;
        sz = sb.size();
        check("count", 64'(count_o), 64'(sz));
        check("deq_valid", 64'(deq_valid_o), 64'(sz > 0));
        check("full", 64'(full_o), 64'(sz == DEPTH));
        check("afull", 64'(afull_o), 64'((DEPTH - sz) <= MARGIN));
        check("overflow", 64'(overflow_o), 64'(m_ovf));
        if (sz > 0) begin
            check("deq_entry", {deq_pc_o, deq_inst_o}, sb[0]);
        end else begin
            check("hold_entry", {deq_pc_o, deq_inst_o}, {m_hold_pc, m_hold_inst});
        end
        fire   = (sz > 0) && rdy && !fl;
        accept = enq && !fl && ((sz < DEPTH) || fire);
        if (enq && !fl && sz == DEPTH && !fire) m_ovf = 1'b1;
        if (fl) begin
            sb.delete();
            m_hold_pc   = PC_RST;
            m_hold_inst = NOP;
        end else begin
            if (sz > 0) begin
                m_hold_pc   = sb[0][63:32];
                m_hold_inst = sb[0][31:0];
            end
            if (fire) void'(sb.pop_front());
            if (accept) sb.push_back({pc, inst});
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_n_i     = 1'b0;
        flush_i     = 1'b0;
        enq_valid_i = 1'b0;
        enq_pc_i    = '0;
        enq_inst_i  = '0;
        deq_ready_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #2;
        check("rst_valid", 64'(deq_valid_o), 64'(0));
        check("rst_count", 64'(count_o), 64'(0));
        check("rst_full", 64'(full_o), 64'(0));
        check("rst_afull", 64'(afull_o), 64'(0));
        check("rst_ovf", 64'(overflow_o), 64'(0));
        check("rst_entry", {deq_pc_o, deq_inst_o}, {PC_RST, NOP});
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int sent;
        logic e;
        logic [31:0] pcs [3];
        logic [31:0] insts [3];
        pcs   = '{32'h1ECE_B000, 32'h1ECE_B004, 32'h1ECE_B008};
        insts = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};

        // 1: three entries, held, then drained in order
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, pcs[i], insts[i], 1'b0, 1'b0);
        check("t1_head_pc", 64'(deq_pc_o), 64'(32'h1ECE_B000));
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // 2: fill to full, 9th dropped, overflow sticky
        for (int i = 0; i < DEPTH + 1; i++)
            cycle(1'b1, 32'h1ECE_B200 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        check("t2_overflow", 64'(overflow_o), 64'(1));
        check("t2_count", 64'(count_o), 64'(DEPTH));

        // 3: enqueue and dequeue together while full
        cycle(1'b1, 32'h1ECE_B300, 32'hB000_0001, 1'b1, 1'b0);
        check("t3_count", 64'(count_o), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // 4: flush with concurrent enq/deq at count 5
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'h1ECE_B400 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h1ECE_B4F0, 32'hC000_00FF, 1'b1, 1'b1);
        cycle(1'b1, 32'h1ECE_B100, 32'h0000_0513, 1'b0, 1'b0);
        check("t4_post_enq_pc", 64'(deq_pc_o), 64'(32'h1ECE_B100));
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // 5: stream with random ready, fetch obeys afull
        do_reset();
        sent = 0;
        for (int c = 0; c < 400 && (sent < 20 || sb.size() > 0); c++) begin
            e = (sent < 20) && !afull_o;
            cycle(e, 32'h1ECE_C000 + 32'(4 * sent), $urandom, 1'($urandom_range(0, 1)), 1'b0);
            if (e) sent++;
        end
        check("t5_sent", 64'(sent), 64'(20));
        check("t5_drained", 64'(sb.size()), 64'(0));
        check("t5_no_ovf", 64'(overflow_o), 64'(0));

        // 6: asynchronous reset mid-stream at count 4
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h1ECE_B600 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
        check("t6_count_before", 64'(count_o), 64'(4));
        enq_valid_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        check("t6_valid", 64'(deq_valid_o), 64'(0));
        check("t6_count", 64'(count_o), 64'(0));
        check("t6_ovf", 64'(overflow_o), 64'(0));
        check("t6_entry", {deq_pc_o, deq_inst_o}, {PC_RST, NOP});
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        cycle(1'b0, '0, '0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
